distance_display_top: RTL and testbench

DISTANCE_DISPLAY_TOP -- requirements
Module: distance_display_top

---
 rtl/distance_display_top.sv | 228 ++++++++++++++++++++++
 tb/tb_distance_display_top.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/distance_display_top.sv
`timescale 1ns/1ps
// Ultrasonic ranger: times the echo pulse in cm (0..999) and sends three 7-segment digits to a strobe/clock/data display.
// A frame starts one cycle after a request; a request that arrives during a frame is held until that frame ends.
module distance_display_top #(
  parameter int PERIOD   = 6_000_000,
  parameter int TRIG_LEN = 1000,
  parameter int PRESCALE = 5800,
  parameter int HALF_BIT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic echo,
  output logic trig,
  output logic stb,
  output logic dio,
  output logic clk_kHz
);
  localparam int PW = $clog2(PERIOD);
  localparam int SW = $clog2(PRESCALE);
  localparam int TW = $clog2(2 * HALF_BIT);
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD - 1);
  localparam logic [PW-1:0] TRIG_END  = PW'(TRIG_LEN);
  localparam logic [SW-1:0] PRE_LAST  = SW'(PRESCALE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(2 * HALF_BIT - 1);
  localparam logic [11:0]   CM_MAX    = 12'd999;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_LOW, S_HIGH, S_POST, S_GAP} state_t;

  logic echo_s1_q, echo_s2_q, echo_s3_q, echo_fall;
  logic [PW-1:0] period_q;
  logic trig_q;
  logic [SW-1:0] presc_q;
  logic [11:0] cm_q, distance_q;
  logic conv_load_q, conv_done;
  logic [3:0] conv_cnt_q;
  logic [23:0] sr_q, sr_step;
  logic [3:0] dig_h_q, dig_t_q, dig_u_q, snap_h_q, snap_t_q, snap_u_q;
  state_t state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0] txn_q, txn_d, bit_q, bit_d;
  logic byte_q, byte_d, req_q, frame_start, last_byte;
  logic [7:0] cur_byte;
  logic stb_q, dio_q, ck_q;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'h3F;
      4'd1: seg7 = 8'h06;
      4'd2: seg7 = 8'h5B;
      4'd3: seg7 = 8'h4F;
      4'd4: seg7 = 8'h66;
      4'd5: seg7 = 8'h6D;
      4'd6: seg7 = 8'h7D;
      4'd7: seg7 = 8'h07;
      4'd8: seg7 = 8'h7F;
      4'd9: seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  // sr layout is {hundreds, tens, units, binary}; one shift-add-3 step per cycle
  function automatic logic [23:0] dd_step(input logic [23:0] s);
    logic [23:0] r;
    r = s;
    for (int i = 0; i < 3; i++)
      if (r[12+4*i +: 4] >= 4'd5) r[12+4*i +: 4] = r[12+4*i +: 4] + 4'd3;
    return {r[22:0], 1'b0};
  endfunction

  assign echo_fall = echo_s3_q & ~echo_s2_q;
  assign sr_step   = dd_step(sr_q);
  assign conv_done = (conv_cnt_q == 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {echo_s1_q, echo_s2_q, echo_s3_q} <= '0;
      period_q <= '0;
      trig_q   <= 1'b0;
    end else begin
      {echo_s1_q, echo_s2_q, echo_s3_q} <= {echo, echo_s1_q, echo_s2_q};
      period_q <= (period_q == PER_LAST) ? '0 : period_q + 1'b1;
      trig_q   <= (period_q < TRIG_END);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      cm_q       <= '0;
      distance_q <= '0;
    end else begin
      if (echo_s2_q) begin
        if (presc_q == PRE_LAST) begin
          presc_q <= '0;
          if (cm_q != CM_MAX) cm_q <= cm_q + 12'd1;
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end else begin
        presc_q <= '0;
      end
      if (echo_fall) begin
        distance_q <= cm_q;
        cm_q       <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_load_q <= 1'b0;
      conv_cnt_q  <= '0;
      sr_q        <= '0;
      {dig_h_q, dig_t_q, dig_u_q} <= '0;
    end else begin
      conv_load_q <= echo_fall;
      if (conv_load_q) begin
        sr_q       <= {12'd0, distance_q};
        conv_cnt_q <= 4'd12;
      end else if (conv_cnt_q != 4'd0) begin
        sr_q       <= sr_step;
        conv_cnt_q <= conv_cnt_q - 4'd1;
        if (conv_done) {dig_h_q, dig_t_q, dig_u_q} <= sr_step[23:12];
      end
    end
  end

  always_comb begin
    cur_byte = 8'h8F;
    case (txn_q)
      3'd0: cur_byte = 8'h44;
      3'd1: cur_byte = byte_q ? seg7(snap_h_q) : 8'hC0;
      3'd2: cur_byte = byte_q ? seg7(snap_t_q) : 8'hC2;
      3'd3: cur_byte = byte_q ? seg7(snap_u_q) : 8'hC4;
      default: cur_byte = 8'h8F;
    endcase
  end

  assign last_byte = (txn_q == 3'd0 || txn_q == 3'd4) ? 1'b1 : byte_q;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q + 1'b1;
    txn_d       = txn_q;
    byte_d      = byte_q;
    bit_d       = bit_q;
    frame_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (req_q) begin
          frame_start = 1'b1;
          state_d = S_PRE;
          txn_d   = '0;
          byte_d  = 1'b0;
          bit_d   = '0;
        end
      end
      S_PRE: if (tmr_q == BIT_LAST) begin state_d = S_LOW; tmr_d = '0; end
      S_LOW: if (tmr_q == HALF_LAST) begin state_d = S_HIGH; tmr_d = '0; end
      S_HIGH: if (tmr_q == HALF_LAST) begin
        tmr_d = '0;
        if (bit_q != 3'd7) begin
          bit_d = bit_q + 3'd1;
          state_d = S_LOW;
        end else if (!last_byte) begin
          bit_d = '0;
          byte_d = 1'b1;
          state_d = S_LOW;
        end else begin
          state_d = S_POST;
        end
      end
      S_POST: if (tmr_q == HALF_LAST) begin state_d = S_GAP; tmr_d = '0; end
      S_GAP: if (tmr_q == BIT_LAST) begin
        tmr_d = '0;
        if (txn_q == 3'd4) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PRE;
          txn_d   = txn_q + 3'd1;
          byte_d  = 1'b0;
          bit_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // req resets to 1 so the first frame (000) goes out right after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      txn_q   <= '0;
      byte_q  <= 1'b0;
      bit_q   <= '0;
      req_q   <= 1'b1;
      {snap_h_q, snap_t_q, snap_u_q} <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      txn_q   <= txn_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      req_q   <= (req_q & ~frame_start) | conv_done;
      if (frame_start) {snap_h_q, snap_t_q, snap_u_q} <= {dig_h_q, dig_t_q, dig_u_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_q <= 1'b1;
      dio_q <= 1'b1;
      ck_q  <= 1'b1;
    end else begin
      stb_q <= (state_q == S_IDLE) || (state_q == S_GAP);
      ck_q  <= (state_q != S_LOW);
      dio_q <= (state_q == S_LOW || state_q == S_HIGH || state_q == S_POST) ? cur_byte[bit_q] : 1'b1;
    end
  end

  assign trig    = trig_q;
  assign stb     = stb_q;
  assign dio     = dio_q;
  assign clk_kHz = ck_q;
endmodule

// File: tb/tb_distance_display_top.sv
`timescale 1ns/1ps
// Bench for distance_display_top with shortened period, prescaler and bit time; frames are decoded off the wire.
module tb_distance_display_top;
  localparam int PERIOD = 3000;
  localparam int TRIG   = 25;
  localparam int PRE    = 5;
  localparam int HB     = 4;
  localparam logic [14:0] LEN_EXP = {3'd1, 3'd2, 3'd2, 3'd2, 3'd1};
  localparam logic [7:0] SEG [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                      8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic echo = 1'b0;
  logic trig, stb, dio, clk_kHz;

  int checks = 0;
  int errors = 0;
  int nf = 0;

  logic [63:0] fr_q [$];
  logic [14:0] len_q [$];
  logic [63:0] fr_acc = '0;
  logic [14:0] fr_len = '0;
  logic [7:0]  sh = '0;
  logic p_ck = 1'b1, p_dio = 1'b1, in_txn = 1'b0, started = 1'b0, first_fall = 1'b0;
  int cyc = 0, t_sf = 0, t_lf = 0, t_lr = 0, t_sr = 0, nbits = 0, fr_txn = 0;
  int tim_bad = 0, dio_bad = 0, idle_bad = 0;

  distance_display_top #(.PERIOD(PERIOD), .TRIG_LEN(TRIG), .PRESCALE(PRE), .HALF_BIT(HB)) u_dut (
    .clk(clk), .rst(rst), .echo(echo), .trig(trig), .stb(stb), .dio(dio), .clk_kHz(clk_kHz)
  );

  always #5 clk = ~clk;

  function automatic int model_cm(input int n);
    return (n / PRE > 999) ? 999 : n / PRE;
  endfunction

  function automatic logic [63:0] exp_frame(input int d);
    return {8'h44, 8'hC0, SEG[d / 100], 8'hC2, SEG[(d / 10) % 10], 8'hC4, SEG[d % 10], 8'h8F};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int n);
    int off;
    off = $urandom_range(1, 9);
    @(posedge clk);
    #(off);
    echo = 1'b1;
    #(n * 10);
    echo = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_frame(input string tag, input int d);
    int k;
    k = 0;
    while (fr_q.size() <= nf && k < 4000) begin @(negedge clk); k++; end
    chk({tag, "_arrived"}, 64'(fr_q.size() > nf), 64'd1);
    if (fr_q.size() > nf) begin
      chk(tag, fr_q[nf], exp_frame(d));
      chk({tag, "_len"}, 64'(len_q[nf]), 64'(LEN_EXP));
      nf++;
    end
  endtask

  // Wire decoder: samples on the falling clk edge, records whole frames and protocol timing faults.
  initial begin : mon
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_txn = 1'b0; started = 1'b0; fr_txn = 0; fr_acc = '0; fr_len = '0;
        p_ck = 1'b1; p_dio = 1'b1;
      end else begin
        if (stb) begin
          if (!dio || !clk_kHz) idle_bad++;
          if (in_txn) begin
            if (cyc - t_lr != 2 * HB || nbits == 0 || nbits % 8 != 0) tim_bad++;
            fr_len = {fr_len[11:0], 3'(nbits / 8)};
            fr_txn++; in_txn = 1'b0; started = 1'b1; t_sr = cyc;
            if (fr_txn == 5) begin
              fr_q.push_back(fr_acc);
              len_q.push_back(fr_len);
              fr_txn = 0; fr_acc = '0; fr_len = '0;
            end
          end
        end else if (!in_txn) begin
          if (started && cyc - t_sr < 2 * HB) tim_bad++;
          in_txn = 1'b1; first_fall = 1'b1; nbits = 0; t_sf = cyc;
        end else begin
          if (p_ck && !clk_kHz) begin
            if (first_fall ? (cyc - t_sf != 2 * HB) : (cyc - t_lr != HB)) tim_bad++;
            first_fall = 1'b0; t_lf = cyc;
          end else if (!p_ck && clk_kHz) begin
            if (cyc - t_lf != HB) tim_bad++;
            if (dio != p_dio) dio_bad++;
            sh = {dio, sh[7:1]}; nbits++; t_lr = cyc;
            if (nbits % 8 == 0) fr_acc = {fr_acc[55:0], sh};
          end else if (clk_kHz && dio != p_dio) begin
            dio_bad++;
          end
        end
        p_ck = clk_kHz; p_dio = dio;
      end
    end
  end

  initial begin
    int k, hi, per, n, n2;
    int dirs [5] = '{4, 5, 172, 4994, 5000};

    #2 rst = 1'b1;
    #2;
    chk("rst_trig", 64'(trig), 64'd0);
    chk("rst_stb", 64'(stb), 64'd1);
    chk("rst_dio", 64'(dio), 64'd1);
    chk("rst_clk_kHz", 64'(clk_kHz), 64'd1);
    #3 rst = 1'b0;
    #1;
    chk("post_rst_trig", 64'(trig), 64'd0);
    chk("post_rst_stb", 64'(stb), 64'd1);
    chk("post_rst_dio", 64'(dio), 64'd1);
    chk("post_rst_clk_kHz", 64'(clk_kHz), 64'd1);

    k = 0;
    while (!trig && k < 10) begin @(negedge clk); k++; end
    chk("trig_rise", 64'(trig), 64'd1);
    hi = 0;
    while (trig && hi < TRIG + 10) begin @(negedge clk); hi++; end
    chk("trig_width", 64'(hi), 64'(TRIG));
    per = hi;
    while (!trig && per < PERIOD + 10) begin @(negedge clk); per++; end
    chk("trig_period", 64'(per), 64'(PERIOD));

    expect_frame("frame_initial", 0);

    foreach (dirs[i]) begin
      pulse(dirs[i]);
      expect_frame($sformatf("frame_echo%0d", dirs[i]), model_cm(dirs[i]));
    end

    for (int i = 0; i < 5; i++) begin
      n = $urandom_range(1, 2000);
      pulse(n);
      expect_frame($sformatf("frame_rand%0d", n), model_cm(n));
    end

    k = 0;
    while (!trig && k < PERIOD + 10) begin @(negedge clk); k++; end
    chk("trig_seen", 64'(trig), 64'd1);
    n = $urandom_range(1, 400);
    pulse(n);
    expect_frame($sformatf("frame_during_trig%0d", n), model_cm(n));

    n  = $urandom_range(20, 300);
    n2 = $urandom_range(5, 200);
    pulse(n);
    repeat (100) @(negedge clk);
    pulse(n2);
    expect_frame($sformatf("held_first%0d", n), model_cm(n));
    expect_frame($sformatf("held_second%0d", n2), model_cm(n2));

    pulse($urandom_range(50, 500));
    k = 0;
    while (stb && k < 300) begin @(negedge clk); k++; end
    chk("midframe_stb_low", 64'(stb), 64'd0);
    repeat (60) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_stb", 64'(stb), 64'd1);
    chk("abort_clk_kHz", 64'(clk_kHz), 64'd1);
    chk("abort_trig", 64'(trig), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_frame("frame_after_abort", 0);

    repeat (1000) @(negedge clk);
    chk("no_extra_frames", 64'(fr_q.size()), 64'(nf));
    chk("stb_clk_timing", 64'(tim_bad), 64'd0);
    chk("dio_stable", 64'(dio_bad), 64'd0);
    chk("idle_levels", 64'(idle_bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
